line_mem_arbiter: RTL and testbench
===================================

# line_mem_arbiter

Line-granular main-memory stage directly downstream of the instruction and data caches. It serves instruction-cache line fills, data-cache line fills and data-cache dirty-line writebacks through one shared backing array with a fixed access latency. Writebacks have strict priority. The two fill streams are arbitrated round-robin. Every completion is a single-cycle pulse that matches the caches' level-held request handshake.

## Interface

Parameters:
- ARCH_BITS, 32, address/word width
- LINE_BITS, 128, memory line width (16 bytes)
- IDX_BITS, 10, line-index width; array depth is 2^IDX_BITS lines
- MEM_LATENCY, 10, cycles from grant to completion pulse; legal range 1..255

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, synchronous, active-high
- i_rd_req  in  1  icache fill request, level, held until i_rd_valid
- i_rd_addr  in  ARCH_BITS  icache fill byte address
- i_rd_data  out  LINE_BITS  fill line for icache
- i_rd_valid  out  1  one-cycle fill-complete pulse
- d_rd_req  in  1  dcache fill request, level
- d_rd_addr  in  ARCH_BITS  dcache fill byte address
- d_rd_data  out  LINE_BITS  fill line for dcache
- d_rd_valid  out  1  one-cycle fill-complete pulse
- d_wr_req  in  1  dcache writeback request, level
- d_wr_addr  in  ARCH_BITS  writeback line-aligned byte address
- d_wr_line  in  LINE_BITS  writeback data
- d_wr_ack  out  1  one-cycle writeback-complete pulse

## Operation

- Line index = addr[4 +: IDX_BITS]:
  - addr[3:0] is ignored.
  - Bits above 4+IDX_BITS are ignored, so addresses alias modulo the array size.
- States:
  - IDLE: no access outstanding.
  - BUSY: access in flight; cnt counts down.
  - RESP: exactly one cycle; the completion pulse is high.
- Grant in IDLE, evaluated at each rising edge, in priority order:
  1. d_wr_req wins unconditionally.
  2. Otherwise, if both read requests are high, the source not granted last wins (round-robin flag last_d).
  3. Otherwise, the single requesting source wins.
  4. While d_wr_req=1, a d_rd_req is never granted: the dcache holds both during an eviction, and the writeback must land first.
- On grant:
  - Latch source id, index, and write line into registers. Later changes to the inputs are ignored.
  - Load cnt=MEM_LATENCY-1 and go to BUSY.
  - For reads, update last_d.
- BUSY:
  - If cnt≠0, decrement.
  - If cnt==0, perform the access and go to RESP:
    - Write: array[idx] <= latched line.
    - Read: the source's rd_data register <= array[idx].
- RESP:
  - The granted source's pulse (i_rd_valid, d_rd_valid or d_wr_ack) is high for this cycle only.
  - Next edge returns to IDLE.
- Abort: if the granted source's req is low at the edge where BUSY would leave:
  - No array write, no pulse.
  - Return to IDLE.
- i_rd_data and d_rd_data hold their last value until overwritten by a later fill to the same source.
- The array is not cleared by rst. Its contents are undefined until written; the bench preloads it hierarchically.

## Timing

- Reset values:
  - State IDLE, cnt=0, last_d=1 (icache wins the first tie).
  - All pulses 0; i_rd_data=0, d_rd_data=0.
- rst asserted mid-transaction:
  - The in-flight access is discarded; no array write and no pulse.
  - rst overrides every other event at that edge.
- Latency:
  - Grant at edge k, pulse high during cycle [k+MEM_LATENCY, k+MEM_LATENCY+1).
  - Back in IDLE at edge k+MEM_LATENCY+1; next grant at the earliest at that same edge.
  - Throughput: one line per MEM_LATENCY+1 cycles.
- Data is valid in the same cycle as its pulse and stable afterwards.
- A request still high in the cycle after its pulse is treated as a new request. A correct cache has dropped it by then.
- Writeback followed by a fill of the same line:
  - The read is granted only after d_wr_ack.
  - It returns the written-back data.
- Simultaneous i_rd_req, d_rd_req and d_wr_req: service order is writeback, then round-robin between the fills.
- At most one pulse is high in any cycle.

## Test plan

- Reset then single icache fill (MEM_LATENCY=10): preload array[0x12]=L0, raise i_rd_req with addr 0x120 at edge 0 -> i_rd_valid high only in cycle 10, i_rd_data=L0.
- Dirty eviction: d_wr_req=d_rd_req=1 together, wr addr 0x340 line W, rd addr 0x740 (IDX_BITS=6 alias index 0x34):
  - d_wr_ack at cycle 10.
  - The bench drops d_wr_req.
  - d_rd_valid at cycle 21 with d_rd_data=W.
- Contention: i_rd_req and d_rd_req both held from reset:
  - icache served first (pulse cycle 10), dcache second (pulse cycle 21).
  - A re-raised icache request and a pending dcache request then alternate strictly.
- Abort: grant an icache fill, drop i_rd_req at cycle 5 -> no i_rd_valid, IDLE by cycle 11, i_rd_data unchanged.
- Reset mid-writeback: rst at cycle 6 of a writeback to index 3 -> no d_wr_ack, array[3] keeps its old value, all outputs 0 after the rst edge.
- MEM_LATENCY=1 corner: back-to-back fills, pulses in cycles 1 and 3, no overlapping pulses.

Source files
------------

// File: rtl/line_mem_arbiter_if.sv
// Cache-side bus of the line memory stage: two line-fill channels and one
// writeback channel, each a level-held request answered by a one-cycle pulse.
interface line_mem_arbiter_if #(
  parameter int ARCH_BITS = 32,
  parameter int LINE_BITS = 128
);
  logic                 i_rd_req;
  logic [ARCH_BITS-1:0] i_rd_addr;
  logic [LINE_BITS-1:0] i_rd_data;
  logic                 i_rd_valid;

  logic                 d_rd_req;
  logic [ARCH_BITS-1:0] d_rd_addr;
  logic [LINE_BITS-1:0] d_rd_data;
  logic                 d_rd_valid;

  logic                 d_wr_req;
  logic [ARCH_BITS-1:0] d_wr_addr;
  logic [LINE_BITS-1:0] d_wr_line;
  logic                 d_wr_ack;

  modport master (
    output i_rd_req, i_rd_addr, d_rd_req, d_rd_addr,
           d_wr_req, d_wr_addr, d_wr_line,
    input  i_rd_data, i_rd_valid, d_rd_data, d_rd_valid, d_wr_ack
  );

  modport slave (
    input  i_rd_req, i_rd_addr, d_rd_req, d_rd_addr,
           d_wr_req, d_wr_addr, d_wr_line,
    output i_rd_data, i_rd_valid, d_rd_data, d_rd_valid, d_wr_ack
  );
endinterface

// File: rtl/line_mem_arbiter.sv
// Line-granular backing memory shared by icache fills, dcache fills and dcache
// writebacks; fixed access latency, writeback first, round-robin between fills.
module line_mem_arbiter #(
  parameter int ARCH_BITS   = 32,
  parameter int LINE_BITS   = 128,
  parameter int IDX_BITS    = 10,
  parameter int MEM_LATENCY = 10
) (
  input logic               clk,
  input logic               rst,
  line_mem_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | no access outstanding
  // BUSY  | access in flight, cnt_q counts down to the array access
  // RESP  | completion pulse of the granted source; next grant may happen here
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;
  typedef enum logic [1:0] {SRC_I = 2'd0, SRC_D = 2'd1, SRC_W = 2'd2} src_e;

  localparam logic [7:0] CNT_LOAD = 8'(MEM_LATENCY - 1);

  state_e               state_q, state_d;
  src_e                 src_q, src_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 last_dc_q, last_dc_d;
  logic [IDX_BITS-1:0]  idx_q, idx_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic [LINE_BITS-1:0] i_data_q, i_data_d;
  logic [LINE_BITS-1:0] d_data_q, d_data_d;
  logic [LINE_BITS-1:0] mem_q [1<<IDX_BITS];

  logic src_req;
  logic access;
  logic mem_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      src_q     <= SRC_I;
      cnt_q     <= 8'd0;
      last_dc_q <= 1'b1;
      idx_q     <= '0;
      line_q    <= '0;
      i_data_q  <= '0;
      d_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      cnt_q     <= cnt_d;
      last_dc_q <= last_dc_d;
      idx_q     <= idx_d;
      line_q    <= line_d;
      i_data_q  <= i_data_d;
      d_data_q  <= d_data_d;
    end
  end

  // The array itself is never reset; rst only suppresses an in-flight write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) mem_q[idx_q] <= line_q;
  end

  always_comb begin
    state_d   = state_q;
    src_d     = src_q;
    cnt_d     = cnt_q;
    last_dc_d = last_dc_q;
    idx_d     = idx_q;
    line_d    = line_q;
    i_data_d  = i_data_q;
    d_data_d  = d_data_q;

    case (src_q)
      SRC_I:   src_req = bus.i_rd_req;
      SRC_D:   src_req = bus.d_rd_req;
      default: src_req = bus.d_wr_req;
    endcase

    // A source that dropped its request before the access edge aborts silently.
    access = (state_q == BUSY) && (cnt_q == 8'd0) && src_req;
    mem_we = access && (src_q == SRC_W);

    case (state_q)
      BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          state_d = src_req ? RESP : IDLE;
          if (access && (src_q == SRC_I)) i_data_d = mem_q[idx_q];
          if (access && (src_q == SRC_D)) d_data_d = mem_q[idx_q];
        end
      end
      default: begin
        state_d = IDLE;
        if (bus.d_wr_req) begin
          state_d = BUSY;
          cnt_d   = CNT_LOAD;
          src_d   = SRC_W;
          idx_d   = bus.d_wr_addr[4 +: IDX_BITS];
          line_d  = bus.d_wr_line;
        end else if (bus.i_rd_req && (!bus.d_rd_req || last_dc_q)) begin
          state_d   = BUSY;
          cnt_d     = CNT_LOAD;
          src_d     = SRC_I;
          idx_d     = bus.i_rd_addr[4 +: IDX_BITS];
          last_dc_d = 1'b0;
        end else if (bus.d_rd_req) begin
          state_d   = BUSY;
          cnt_d     = CNT_LOAD;
          src_d     = SRC_D;
          idx_d     = bus.d_rd_addr[4 +: IDX_BITS];
          last_dc_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    bus.i_rd_valid = (state_q == RESP) && (src_q == SRC_I);
    bus.d_rd_valid = (state_q == RESP) && (src_q == SRC_D);
    bus.d_wr_ack   = (state_q == RESP) && (src_q == SRC_W);
    bus.i_rd_data  = i_data_q;
    bus.d_rd_data  = d_data_q;
  end
endmodule

// File: tb/tb_line_mem_arbiter.sv
// Directed bench for line_mem_arbiter: one instance at latency 10 and one at
// latency 1, both with a 64-line array so address aliasing can be exercised.
module tb_line_mem_arbiter;
  localparam int AB = 32;
  localparam int LB = 128;
  localparam int IB = 6;

  localparam logic [LB-1:0] L0   = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [LB-1:0] W    = 128'hdeadbeef_00000001_cafef00d_00000002;
  localparam logic [LB-1:0] OLD  = 128'h11111111_11111111_11111111_11111111;
  localparam logic [LB-1:0] JUNK = 128'hffffffff_eeeeeeee_dddddddd_cccccccc;
  localparam logic [LB-1:0] A1   = 128'ha1a1a1a1_00000000_00000000_000000a1;
  localparam logic [LB-1:0] A2   = 128'ha2a2a2a2_00000000_00000000_000000a2;
  localparam logic [LB-1:0] A5   = 128'ha5a5a5a5_00000000_00000000_000000a5;
  localparam logic [LB-1:0] OLD3 = 128'h03030303_0a0a0a0a_03030303_0a0a0a0a;
  localparam logic [LB-1:0] NEW3 = 128'h30303030_b0b0b0b0_30303030_b0b0b0b0;
  localparam logic [LB-1:0] B7   = 128'hb7b7b7b7_00000000_11111111_000000b7;
  localparam logic [LB-1:0] B8   = 128'hb8b8b8b8_00000000_22222222_000000b8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  line_mem_arbiter_if #(.ARCH_BITS(AB), .LINE_BITS(LB)) ifa ();
  line_mem_arbiter_if #(.ARCH_BITS(AB), .LINE_BITS(LB)) ifb ();

  line_mem_arbiter #(.ARCH_BITS(AB), .LINE_BITS(LB), .IDX_BITS(IB), .MEM_LATENCY(10))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  line_mem_arbiter #(.ARCH_BITS(AB), .LINE_BITS(LB), .IDX_BITS(IB), .MEM_LATENCY(1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Pulse vector {i_rd_valid, d_rd_valid, d_wr_ack}
  function automatic logic [2:0] pa();
    return {ifa.i_rd_valid, ifa.d_rd_valid, ifa.d_wr_ack};
  endfunction

  function automatic logic [2:0] pb();
    return {ifb.i_rd_valid, ifb.d_rd_valid, ifb.d_wr_ack};
  endfunction

  initial begin
    rst = 1'b1;
    ifa.i_rd_req = 1'b0; ifa.i_rd_addr = '0;
    ifa.d_rd_req = 1'b0; ifa.d_rd_addr = '0;
    ifa.d_wr_req = 1'b0; ifa.d_wr_addr = '0; ifa.d_wr_line = '0;
    ifb.i_rd_req = 1'b0; ifb.i_rd_addr = '0;
    ifb.d_rd_req = 1'b0; ifb.d_rd_addr = '0;
    ifb.d_wr_req = 1'b0; ifb.d_wr_addr = '0; ifb.d_wr_line = '0;
    repeat (3) tick();

    chk("reset pulses a", pa(), 3'b000);
    chk("reset pulses b", pb(), 3'b000);
    chk("reset i_rd_data", ifa.i_rd_data, '0);
    chk("reset d_rd_data", ifa.d_rd_data, '0);

    // Single icache fill: index 0x12, pulse only in cycle 10
    dut_a.mem_q[18] = L0;
    rst = 1'b0;
    ifa.i_rd_req = 1'b1; ifa.i_rd_addr = 32'h0000_0120;
    for (int c = 0; c <= 11; c++) begin
      tick();
      chk($sformatf("fill pulse c%0d", c), pa(), (c == 10) ? 3'b100 : 3'b000);
      if (c == 10) begin
        chk("fill i_rd_data", ifa.i_rd_data, L0);
        ifa.i_rd_req = 1'b0;
      end
    end

    // Dirty eviction: writeback 0x340 first, then aliased fill 0x740 returns W
    dut_a.mem_q[52] = OLD;
    ifa.d_wr_req = 1'b1; ifa.d_wr_addr = 32'h0000_0340; ifa.d_wr_line = W;
    ifa.d_rd_req = 1'b1; ifa.d_rd_addr = 32'h0000_0740;
    for (int c = 0; c <= 22; c++) begin
      tick();
      chk($sformatf("evict pulse c%0d", c), pa(),
          (c == 10) ? 3'b001 : (c == 21) ? 3'b010 : 3'b000);
      if (c == 3) begin
        ifa.d_wr_line = JUNK; ifa.d_wr_addr = 32'h0000_0350;
      end
      if (c == 10) ifa.d_wr_req = 1'b0;
      if (c == 21) begin
        chk("evict d_rd_data", ifa.d_rd_data, W);
        ifa.d_rd_req = 1'b0;
      end
    end

    // Contention from reset: both fills held, services alternate i, d, i, d
    rst = 1'b1;
    repeat (2) tick();
    chk("rerst i_rd_data", ifa.i_rd_data, '0);
    chk("rerst d_rd_data", ifa.d_rd_data, '0);
    dut_a.mem_q[1] = A1;
    dut_a.mem_q[2] = A2;
    rst = 1'b0;
    ifa.i_rd_req = 1'b1; ifa.i_rd_addr = 32'h0000_0010;
    ifa.d_rd_req = 1'b1; ifa.d_rd_addr = 32'h0000_0020;
    for (int c = 0; c <= 44; c++) begin
      tick();
      chk($sformatf("rr pulse c%0d", c), pa(),
          (c == 10 || c == 32) ? 3'b100 : (c == 21 || c == 43) ? 3'b010 : 3'b000);
      if (c == 10) chk("rr i_rd_data", ifa.i_rd_data, A1);
      if (c == 21) chk("rr d_rd_data", ifa.d_rd_data, A2);
      if (c == 43) begin
        ifa.i_rd_req = 1'b0; ifa.d_rd_req = 1'b0;
      end
    end

    // Abort: icache drops its request mid-flight; a fresh fill then completes
    dut_a.mem_q[5] = A5;
    ifa.i_rd_req = 1'b1; ifa.i_rd_addr = 32'h0000_0050;
    for (int c = 0; c <= 22; c++) begin
      tick();
      chk($sformatf("abort pulse c%0d", c), pa(), (c == 21) ? 3'b100 : 3'b000);
      if (c == 5) ifa.i_rd_req = 1'b0;
      if (c == 10) begin
        chk("abort i_rd_data kept", ifa.i_rd_data, A1);
        ifa.i_rd_req = 1'b1;
      end
      if (c == 21) begin
        chk("refill i_rd_data", ifa.i_rd_data, A5);
        ifa.i_rd_req = 1'b0;
      end
    end

    // Reset at edge 6 of a writeback to index 3; a later fill sees the old line
    dut_a.mem_q[3] = OLD3;
    ifa.d_wr_req = 1'b1; ifa.d_wr_addr = 32'h0000_0030; ifa.d_wr_line = NEW3;
    for (int c = 0; c <= 24; c++) begin
      tick();
      chk($sformatf("rstwb pulse c%0d", c), pa(), (c == 23) ? 3'b010 : 3'b000);
      if (c == 5) rst = 1'b1;
      if (c == 6) begin
        chk("rstwb i_rd_data", ifa.i_rd_data, '0);
        chk("rstwb d_rd_data", ifa.d_rd_data, '0);
        rst = 1'b0;
        ifa.d_wr_req = 1'b0;
      end
      if (c == 12) begin
        ifa.d_rd_req = 1'b1; ifa.d_rd_addr = 32'h0000_0030;
      end
      if (c == 23) begin
        chk("rstwb array kept", ifa.d_rd_data, OLD3);
        ifa.d_rd_req = 1'b0;
      end
    end

    // Latency-1 instance: back-to-back fills pulse in cycles 1 and 3
    dut_b.mem_q[7] = B7;
    dut_b.mem_q[8] = B8;
    ifb.i_rd_req = 1'b1; ifb.i_rd_addr = 32'h0000_0070;
    ifb.d_rd_req = 1'b1; ifb.d_rd_addr = 32'h0000_0080;
    for (int c = 0; c <= 5; c++) begin
      tick();
      chk($sformatf("lat1 pulse c%0d", c), pb(),
          (c == 1) ? 3'b100 : (c == 3) ? 3'b010 : 3'b000);
      if (c == 1) begin
        chk("lat1 i_rd_data", ifb.i_rd_data, B7);
        ifb.i_rd_req = 1'b0;
      end
      if (c == 3) begin
        chk("lat1 d_rd_data", ifb.d_rd_data, B8);
        ifb.d_rd_req = 1'b0;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
